// File: rtl/ps2_device_tx_if.sv
// ps2_device_tx_if
// Byte handshake between a byte source (master) and the PS/2 device-side
// transmitter (slave).
//   i_data   master -> slave  byte to send, stable while i_valid is high
//   i_valid  master -> slave  send request, held until accepted
//   i_break  master -> slave  prefix the byte with 0xF0 (PS2_TX_BREAK_EN builds only)
//   o_ready  slave  -> master accept possible this cycle
//   o_done   slave  -> master one-cycle pulse, frame fully sent
//   o_abort  slave  -> master one-cycle pulse, frame dropped on host inhibit
// Macro: PS2_TX_BREAK_EN adds i_break.
interface ps2_device_tx_if;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       o_done;
    logic       o_abort;
`ifdef PS2_TX_BREAK_EN
    logic       i_break;

    modport master (output i_data, i_valid, i_break, input o_ready, o_done, o_abort);
    modport slave  (input i_data, i_valid, i_break, output o_ready, o_done, o_abort);
`else
    modport master (output i_data, i_valid, input o_ready, o_done, o_abort);
    modport slave  (input i_data, i_valid, output o_ready, o_done, o_abort);
`endif
endinterface

// File: rtl/ps2_device_tx.sv
// ps2_device_tx
// PS/2 device-side (keyboard emulator) frame transmitter. Accepts a byte over
// the bus interface and sends start 0, eight data bits LSB first, odd parity
// and stop 1, generating the PS/2 clock itself. Both line outputs are
// open-drain style: 1 = release, 0 = pull low.
// Ports:
//   i_clk       system clock
//   i_rst_n     asynchronous active-low reset
//   bus         ps2_device_tx_if.slave (i_data, i_valid, [i_break], o_ready, o_done, o_abort)
//   i_ps2_clk   sampled PS/2 clock line, synchronised here, for host-inhibit detection
//   o_ps2_clk   clock line drive
//   o_ps2_data  data line drive
// Macro: PS2_TX_BREAK_EN enables i_break: send 0xF0, wait for an idle line,
// then send the byte; o_done pulses only after the second frame.
//
// state  | meaning
// IDLE   | lines released, waiting for an idle line and a request
// HIGH   | clock released, data = current bit; host may inhibit here
// LOW    | clock pulled low, data held
// TAIL   | both lines released for one half-period after the stop bit
// GAP    | break only: waiting for an idle line between 0xF0 and the byte
module ps2_device_tx #(
    parameter int HALF_CYC = 2500,
    parameter int IDLE_CYC = 2500
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    ps2_device_tx_if.slave bus,
    input  logic           i_ps2_clk,
    output logic           o_ps2_clk,
    output logic           o_ps2_data
);
    localparam int PW = $clog2(HALF_CYC + 1);
    localparam int IW = $clog2(IDLE_CYC + 1);

    localparam logic [PW-1:0] PH_LAST   = PW'(HALF_CYC - 1);
    localparam logic [PW-1:0] INH_START = PW'(2);
    localparam logic [IW-1:0] IDLE_FULL = IW'(IDLE_CYC);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HIGH = 3'd1;
    localparam logic [2:0] S_LOW  = 3'd2;
    localparam logic [2:0] S_TAIL = 3'd3;
`ifdef PS2_TX_BREAK_EN
    localparam logic [2:0] S_GAP  = 3'd4;
`endif

    logic [2:0]    r_state;
    logic [PW-1:0] r_phase;
    logic [3:0]    r_bit_cnt;
    logic [10:0]   r_shift;
    logic [IW-1:0] r_idle_cnt;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_done;
    logic          r_abort;
`ifdef PS2_TX_BREAK_EN
    logic          r_pending;
    logic [7:0]    r_data2;
`endif

    logic w_line_idle;
    logic w_counting;
    logic w_accept;
    logic w_phase_end;
    logic w_inhibit;

    function automatic logic [10:0] f_frame(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction

    // Synchroniser resets to the released level so an idle line is
    // recognised IDLE_CYC cycles after reset without extra sync latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_ps2_clk;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PS2_TX_BREAK_EN
    assign w_counting = (r_state == S_IDLE) || (r_state == S_GAP);
`else
    assign w_counting = (r_state == S_IDLE);
`endif

    // Held at zero while a frame is in flight, so every return to idle
    // restarts the line-idle measurement.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idle_cnt <= '0;
        end else if (!w_counting || !r_sync2) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != IDLE_FULL) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    assign w_line_idle = (r_idle_cnt == IDLE_FULL);
    assign w_accept    = bus.i_valid && bus.o_ready;
    assign w_phase_end = (r_phase == PH_LAST);
    // The first two HIGH cycles still see our own low clock through the
    // synchroniser, so the inhibit check starts at phase count 2.
    assign w_inhibit   = (r_state == S_HIGH) && (r_bit_cnt <= 4'd9) &&
                         (r_phase >= INH_START) && !r_sync2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_phase   <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '1;
            r_done    <= 1'b0;
            r_abort   <= 1'b0;
`ifdef PS2_TX_BREAK_EN
            r_pending <= 1'b0;
            r_data2   <= '0;
`endif
        end else begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_phase   <= '0;
                    r_bit_cnt <= '0;
                    if (w_accept) begin
                        r_state <= S_HIGH;
`ifdef PS2_TX_BREAK_EN
                        r_pending <= bus.i_break;
                        r_data2   <= bus.i_data;
                        r_shift   <= bus.i_break ? f_frame(8'hF0) : f_frame(bus.i_data);
`else
                        r_shift <= f_frame(bus.i_data);
`endif
                    end
                end
                S_HIGH: begin
                    if (w_inhibit) begin
                        r_state   <= S_IDLE;
                        r_abort   <= 1'b1;
                        r_phase   <= '0;
                        r_bit_cnt <= '0;
`ifdef PS2_TX_BREAK_EN
                        r_pending <= 1'b0;
`endif
                    end else if (w_phase_end) begin
                        r_state <= S_LOW;
                        r_phase <= '0;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                S_LOW: begin
                    if (w_phase_end) begin
                        r_phase <= '0;
                        r_shift <= {1'b1, r_shift[10:1]};
                        if (r_bit_cnt == 4'd10) begin
                            r_state   <= S_TAIL;
                            r_bit_cnt <= '0;
                        end else begin
                            r_state   <= S_HIGH;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                S_TAIL: begin
                    if (w_phase_end) begin
                        r_phase <= '0;
`ifdef PS2_TX_BREAK_EN
                        if (r_pending) begin
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
`else
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
`ifdef PS2_TX_BREAK_EN
                S_GAP: begin
                    r_phase   <= '0;
                    r_bit_cnt <= '0;
                    if (w_line_idle) begin
                        r_state   <= S_HIGH;
                        r_shift   <= f_frame(r_data2);
                        r_pending <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Data only moves when the shift register shifts at the end of LOW,
    // i.e. at the start of HIGH, never while the clock is low.
    assign o_ps2_clk   = (r_state != S_LOW);
    assign o_ps2_data  = ((r_state == S_HIGH) || (r_state == S_LOW)) ? r_shift[0] : 1'b1;
    assign bus.o_ready = (r_state == S_IDLE) && w_line_idle;
    assign bus.o_done  = r_done;
    assign bus.o_abort = r_abort;
endmodule

// File: tb/tb_ps2_device_tx.sv
module tb_ps2_device_tx;
    localparam int HALF = 5;
    localparam int IDLE = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic force_low = 1'b0;
    logic o_ps2_clk;
    logic o_ps2_data;
    logic w_ps2_clk_in;

    ps2_device_tx_if bus();

    assign w_ps2_clk_in = force_low ? 1'b0 : o_ps2_clk;

    ps2_device_tx #(.HALF_CYC(HALF), .IDLE_CYC(IDLE)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .bus        (bus),
        .i_ps2_clk  (w_ps2_clk_in),
        .o_ps2_clk  (o_ps2_clk),
        .o_ps2_data (o_ps2_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: acts as the receiver (samples data on clock falling edges)
    // and records completion/abort events.
    logic       prev_clk = 1'b1;
    logic       prev_data = 1'b1;
    logic       q_bits[$];
    int         q_done[$];
    int         n_fall = 0;
    int         n_done = 0;
    int         n_abort = 0;
    int         n_viol = 0;
    int         rel_run = 0;
    int         t_abort = 0;
    logic [1:0] abort_lines = 2'b00;

    always @(negedge clk) begin
        if (prev_clk && !o_ps2_clk) begin
            q_bits.push_back(o_ps2_data);
            n_fall <= n_fall + 1;
        end
        if (!prev_clk && !o_ps2_clk && (o_ps2_data !== prev_data))
            n_viol <= n_viol + 1;
        if (bus.o_done) begin
            n_done <= n_done + 1;
            q_done.push_back(cyc);
        end
        if (bus.o_abort) begin
            n_abort     <= n_abort + 1;
            t_abort     <= cyc;
            abort_lines <= {o_ps2_clk, o_ps2_data};
        end
        rel_run   <= (o_ps2_clk && o_ps2_data) ? rel_run + 1 : 0;
        prev_clk  <= o_ps2_clk;
        prev_data <= o_ps2_data;
    end

    int n_checks = 0;
    int n_fail = 0;

    // Expected frame from the line protocol: bit k of the result is the k-th
    // bit on the wire (start, data LSB first, odd parity, stop).
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f = '0;
        for (int k = 0; k < 8; k++) begin
            f[k + 1] = ((int'(b) >> k) % 2) == 1;
            ones += (int'(b) >> k) % 2;
        end
        f[9]  = (ones % 2) == 0;
        f[10] = 1'b1;
        return f;
    endfunction

    function automatic logic [10:0] rx_frame(input int base);
        logic [10:0] f;
        f = 'x;
        for (int k = 0; k < 11; k++)
            if (base + k < q_bits.size()) f[k] = q_bits[base + k];
        return f;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int budget, output int t_acc, output bit ok);
        ok = 1'b0;
        t_acc = 0;
        bus.i_data = b;
        bus.i_valid = 1'b1;
        for (int i = 0; i < budget && !ok; i++) begin
            if (bus.o_ready) begin
                ok = 1'b1;
                t_acc = cyc;
            end
            tick();
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        ok = (n_done >= target);
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = (n_done >= target);
        end
    endtask

    task automatic test_reset();
        int r, t_rdy;
        bit bad;
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({o_ps2_clk, o_ps2_data, bus.o_ready, bus.o_done, bus.o_abort} !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_values got=%b exp=11000",
                     {o_ps2_clk, o_ps2_data, bus.o_ready, bus.o_done, bus.o_abort});
        end
        rst_n = 1'b1;
        r = cyc;
        t_rdy = -1;
        bad = 1'b0;
        for (int i = 0; i < 30 && t_rdy < 0; i++) begin
            tick();
            if (bus.o_ready) t_rdy = cyc;
            else if ({o_ps2_clk, o_ps2_data, bus.o_done, bus.o_abort} !== 4'b1100) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL reset_hold outputs left reset values before ready");
        end
        n_checks++;
        if (t_rdy - r != IDLE) begin
            n_fail++;
            $display("FAIL reset_ready_delay got=%0d exp=%0d", t_rdy - r, IDLE);
        end
    endtask

    task automatic test_single();
        int t_acc, b_fall, b_bits, b_done, b_abort;
        bit ok;
        logic [10:0] rx;
        b_fall = n_fall; b_bits = q_bits.size(); b_done = n_done; b_abort = n_abort;
        send(8'h1C, 50, t_acc, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL single_accept timeout"); end
        wait_done(b_done + 1, 300, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL single_done timeout"); end
        else begin
            n_checks++;
            if (q_done[$] - t_acc != 23 * HALF + 1) begin
                n_fail++;
                $display("FAIL single_latency got=%0d exp=%0d", q_done[$] - t_acc, 23 * HALF + 1);
            end
        end
        rx = rx_frame(b_bits);
        n_checks++;
        if (rx !== 11'b100_0011_1000) begin
            n_fail++;
            $display("FAIL single_bits got=%b exp=%b", rx, 11'b100_0011_1000);
        end
        n_checks++;
        if (rx[8:1] !== 8'h1C || rx[9] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rx_byte got=%h par=%b exp=1c par=0", rx[8:1], rx[9]);
        end
        n_checks++;
        if (n_fall - b_fall != 11) begin
            n_fail++;
            $display("FAIL single_falls got=%0d exp=11", n_fall - b_fall);
        end
        n_checks++;
        if (n_abort != b_abort) begin
            n_fail++;
            $display("FAIL single_no_abort got=%0d exp=%0d", n_abort, b_abort);
        end
    endtask

    task automatic test_random();
        int t_acc, b_bits, b_done;
        bit ok;
        logic [7:0] b;
        logic [10:0] rx;
        for (int n = 0; n < 4; n++) begin
            b = 8'($urandom);
            b_bits = q_bits.size(); b_done = n_done;
            send(b, 50, t_acc, ok);
            if (ok) wait_done(b_done + 1, 300, ok);
            rx = rx_frame(b_bits);
            n_checks++;
            if (!ok || rx !== model_frame(b)) begin
                n_fail++;
                $display("FAIL random_frame byte=%h got=%b exp=%b ok=%0d", b, rx, model_frame(b), ok);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2, b_bits, b_done, run_at_acc;
        bit ok1, ok2, ok;
        logic [10:0] rx1, rx2;
        b_bits = q_bits.size(); b_done = n_done;
        bus.i_data = 8'h00;
        bus.i_valid = 1'b1;
        ok1 = 1'b0; ok2 = 1'b0; t1 = 0; t2 = 0; run_at_acc = 0;
        for (int i = 0; i < 50 && !ok1; i++) begin
            if (bus.o_ready) begin ok1 = 1'b1; t1 = cyc; end
            tick();
        end
        bus.i_data = 8'hFF;
        for (int i = 0; i < 400 && !ok2; i++) begin
            if (bus.o_ready) begin ok2 = 1'b1; t2 = cyc; run_at_acc = rel_run; end
            tick();
        end
        bus.i_valid = 1'b0;
        n_checks++;
        if (!ok1 || !ok2) begin
            n_fail++;
            $display("FAIL b2b_accept timeout ok1=%0d ok2=%0d", ok1, ok2);
        end
        wait_done(b_done + 2, 300, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_done timeout"); end
        rx1 = rx_frame(b_bits);
        rx2 = rx_frame(b_bits + 11);
        n_checks++;
        if (rx1 !== model_frame(8'h00) || rx1[9] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first got=%b exp=%b", rx1, model_frame(8'h00));
        end
        n_checks++;
        if (rx2 !== model_frame(8'hFF) || rx2[9] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second got=%b exp=%b", rx2, model_frame(8'hFF));
        end
        // Released-line time before the second start, counted through the accept cycle.
        n_checks++;
        if (run_at_acc < HALF + IDLE) begin
            n_fail++;
            $display("FAIL b2b_gap released=%0d min=%0d (t1=%0d t2=%0d)", run_at_acc, HALF + IDLE, t1, t2);
        end
    endtask

    task automatic test_abort();
        int t_acc, b_fall, b_done, b_abort, c, e, t_rdy;
        bit ok, found;
        b_fall = n_fall; b_done = n_done; b_abort = n_abort;
        send(8'($urandom), 50, t_acc, ok);
        found = 1'b0;
        c = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (n_fall - b_fall == 4 && o_ps2_clk) begin
                found = 1'b1;
                c = cyc;
            end else begin
                tick();
            end
        end
        n_checks++;
        if (!ok || !found) begin
            n_fail++;
            $display("FAIL abort_reach_bit4 timeout ok=%0d found=%0d", ok, found);
        end
        force_low = 1'b1;
        repeat (10) tick();
        force_low = 1'b0;
        e = cyc;
        t_rdy = -1;
        for (int i = 0; i < 40 && t_rdy < 0; i++) begin
            if (bus.o_ready) t_rdy = cyc;
            else tick();
        end
        n_checks++;
        if (n_abort - b_abort != 1) begin
            n_fail++;
            $display("FAIL abort_count got=%0d exp=1", n_abort - b_abort);
        end
        n_checks++;
        if (t_abort - c < 1 || t_abort - c > 3) begin
            n_fail++;
            $display("FAIL abort_delay got=%0d exp=1..3", t_abort - c);
        end
        n_checks++;
        if (abort_lines !== 2'b11) begin
            n_fail++;
            $display("FAIL abort_lines got=%b exp=11", abort_lines);
        end
        n_checks++;
        if (n_done != b_done || n_fall - b_fall != 4) begin
            n_fail++;
            $display("FAIL abort_no_done done=%0d exp=%0d falls=%0d exp=4",
                     n_done - b_done, 0, n_fall - b_fall);
        end
        n_checks++;
        if (t_rdy < e + IDLE || t_rdy > e + IDLE + 2) begin
            n_fail++;
            $display("FAIL abort_ready got=%0d exp=%0d..%0d", t_rdy - e, IDLE, IDLE + 2);
        end
    endtask

    task automatic test_reset_mid();
        int t_acc, b_fall, b_done, b_abort, r, t_rdy;
        bit ok, found;
        b_fall = n_fall; b_done = n_done; b_abort = n_abort;
        send(8'($urandom), 50, t_acc, ok);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            found = (n_fall - b_fall == 7);
        end
        tick();
        tick();
        n_checks++;
        if (!ok || !found || o_ps2_clk !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_reach_low ok=%0d found=%0d clk=%b exp clk=0", ok, found, o_ps2_clk);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_ps2_clk, o_ps2_data, bus.o_ready, bus.o_done, bus.o_abort} !== 5'b11000) begin
            n_fail++;
            $display("FAIL rstmid_async got=%b exp=11000",
                     {o_ps2_clk, o_ps2_data, bus.o_ready, bus.o_done, bus.o_abort});
        end
        repeat (3) tick();
        rst_n = 1'b1;
        r = cyc;
        t_rdy = -1;
        for (int i = 0; i < 30 && t_rdy < 0; i++) begin
            tick();
            if (bus.o_ready) t_rdy = cyc;
        end
        n_checks++;
        if (t_rdy - r != IDLE) begin
            n_fail++;
            $display("FAIL rstmid_ready got=%0d exp=%0d", t_rdy - r, IDLE);
        end
        n_checks++;
        if (n_done != b_done || n_abort != b_abort || n_fall - b_fall != 7) begin
            n_fail++;
            $display("FAIL rstmid_quiet done=%0d abort=%0d falls=%0d exp 0 0 7",
                     n_done - b_done, n_abort - b_abort, n_fall - b_fall);
        end
    endtask

`ifdef PS2_TX_BREAK_EN
    task automatic test_break();
        int t_acc, b_bits, b_done;
        bit ok;
        logic [10:0] rx1, rx2;
        b_bits = q_bits.size(); b_done = n_done;
        bus.i_break = 1'b1;
        send(8'h1C, 50, t_acc, ok);
        bus.i_break = 1'b0;
        if (ok) wait_done(b_done + 1, 600, ok);
        repeat (30) tick();
        n_checks++;
        if (!ok || n_done - b_done != 1) begin
            n_fail++;
            $display("FAIL break_done ok=%0d count=%0d exp=1", ok, n_done - b_done);
        end
        rx1 = rx_frame(b_bits);
        rx2 = rx_frame(b_bits + 11);
        n_checks++;
        if (rx1 !== model_frame(8'hF0) || rx2 !== model_frame(8'h1C)) begin
            n_fail++;
            $display("FAIL break_frames got=%b,%b exp=%b,%b", rx1, rx2, model_frame(8'hF0), model_frame(8'h1C));
        end
    endtask
`endif

    task automatic test_line_discipline();
        n_checks++;
        if (n_viol != 0) begin
            n_fail++;
            $display("FAIL data_while_clk_low changes=%0d exp=0", n_viol);
        end
    endtask

    initial begin
        bus.i_data = 8'h00;
        bus.i_valid = 1'b0;
`ifdef PS2_TX_BREAK_EN
        bus.i_break = 1'b0;
`endif
        test_reset();
        test_single();
        test_random();
        test_back_to_back();
        test_abort();
        test_reset_mid();
`ifdef PS2_TX_BREAK_EN
        test_break();
`endif
        test_line_discipline();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
